// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: instruction fields,
// ALU operation codes, datapath select encodings, FSM states and the
// per-state control word.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_A  = 1'b1;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_A      = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_ALU_WB,
        S_EXEC_I,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR
    } state_t;

    // Raw control word for one state; ir_write/pc_write in FETCH are
    // qualified by mem_ready at the top level.
    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic [1:0] pc_source;
    } ctrl_t;

    // Control word asserted while sitting in state s. r_alu is only
    // consulted for the R-type execute step.
    function automatic ctrl_t ctrl_for(state_t s, logic [3:0] r_alu);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.alu_ctrl  = ALU_ADD;
                c.pc_source = PCS_ALU;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_ctrl  = ALU_ADD;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
                c.alu_ctrl  = ALU_ADD;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RT;
                c.mem_to_reg = WB_MDR;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_B;
                c.alu_ctrl  = r_alu;
            end
            S_ALU_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RD;
                c.mem_to_reg = WB_ALUOUT;
            end
            S_I_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RT;
                c.mem_to_reg = WB_ALUOUT;
            end
            S_BRANCH: begin
                c.alu_src_a     = SRCA_A;
                c.alu_src_b     = SRCB_B;
                c.alu_ctrl      = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCS_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
            end
            S_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PCS_JUMP;
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RA;
                c.mem_to_reg = WB_PC;
            end
            S_JR: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_A;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct to ALU operation decode. valid is low for any funct the
// execute step cannot perform (jr is steered away before execute).
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       valid
);

    // Map funct to an ALU code; unknown codes fall back to ADD, flagged invalid.
    always_comb begin
        alu_ctrl = ALU_ADD;
        valid    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the MIPS-subset datapath.
// Optional build macro MC_CTRL_PERF_EN adds cycle_count and instr_retired.
//
// state      | meaning
// -----------+--------------------------------------------------------
// FETCH      | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE     | branch target into ALUOut, dispatch on opcode
// MEM_ADDR   | effective address A + imm
// MEM_RD     | load access, held until mem_ready
// MEM_WB     | MDR -> rt
// MEM_WR     | store access, held until mem_ready
// EXEC_R     | R-type ALU op from funct
// ALU_WB     | ALUOut -> rd
// EXEC_I     | addi: A + imm
// I_WB       | ALUOut -> rt
// BRANCH     | beq compare, PC <= ALUOut when zero
// JUMP       | PC <= jump target
// JAL        | PC <= jump target, PC -> RA_REG
// JR         | PC <= A
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  pc_source,
    output logic        illegal
`ifdef MC_CTRL_PERF_EN
   ,output logic [31:0] cycle_count,
    output logic [31:0] instr_retired
`endif
);

    // The link register is selected by the datapath through reg_dst=10;
    // register 0 is hardwired and would silently drop the return address.
    if (RA_REG == 5'd0) begin : g_ra_reg_check
        $error("multicycle_control: RA_REG must not be register 0");
    end

    state_t     state;
    state_t     nxt;
    ctrl_t      ctl;
    logic       bad_exit;
    logic       illegal_q;
    logic [3:0] r_alu;
    logic       r_valid;

    mc_alu_decoder u_alu_dec (
        .funct    (funct),
        .alu_ctrl (r_alu),
        .valid    (r_valid)
    );

    // Next-state selection; bad_exit marks a return to FETCH on an unsupported encoding.
    always_comb begin
        nxt      = state;
        bad_exit = 1'b0;
        case (state)
            S_FETCH:    if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_RTYPE:     nxt = (funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_ADDI:      nxt = S_EXEC_I;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_JAL:       nxt = S_JAL;
                    default: begin
                        nxt      = S_FETCH;
                        bad_exit = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) nxt = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) nxt = S_FETCH;
            S_EXEC_R: begin
                if (r_valid) begin
                    nxt = S_ALU_WB;
                end else begin
                    nxt      = S_FETCH;
                    bad_exit = 1'b1;
                end
            end
            S_EXEC_I:   nxt = S_I_WB;
            default:    nxt = S_FETCH;
        endcase
    end

    // State register with the control word registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            ctl       <= ctrl_for(S_FETCH, ALU_ADD);
            illegal_q <= 1'b0;
`ifdef MC_CTRL_PERF_EN
            cycle_count   <= '0;
            instr_retired <= '0;
`endif
        end else begin
            state     <= nxt;
            ctl       <= ctrl_for(nxt, r_alu);
            illegal_q <= bad_exit;
`ifdef MC_CTRL_PERF_EN
            cycle_count <= cycle_count + 32'd1;
            if ((state != S_FETCH) && (nxt == S_FETCH) && !bad_exit) begin
                instr_retired <= instr_retired + 32'd1;
            end
`endif
        end
    end

    // FETCH only commits IR and PC+4 in the cycle memory returns the word;
    // reset masks them so nothing loads while rst_n is low.
    assign ir_write   = rst_n & ctl.ir_write & mem_ready;
    assign pc_en      = rst_n & ((ctl.pc_write & (mem_ready | (state != S_FETCH)))
                                | (ctl.pc_write_cond & zero));
    assign i_or_d     = ctl.i_or_d;
    assign mem_read   = ctl.mem_read;
    assign mem_write  = ctl.mem_write;
    assign reg_write  = ctl.reg_write;
    assign reg_dst    = ctl.reg_dst;
    assign mem_to_reg = ctl.mem_to_reg;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign alu_ctrl   = ctl.alu_ctrl;
    assign pc_source  = ctl.pc_source;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instructions from the
// bring-up list followed by randomized instruction streams with random wait
// states, compared cycle by cycle against an instruction-level model.
module tb_multicycle_control;

    localparam logic [5:0] R_OP  = 6'b000000;
    localparam logic [5:0] LW_OP = 6'b100011;
    localparam logic [5:0] SW_OP = 6'b101011;
    localparam logic [5:0] BEQ_OP = 6'b000100;
    localparam logic [5:0] ADDI_OP = 6'b001000;
    localparam logic [5:0] J_OP  = 6'b000010;
    localparam logic [5:0] JAL_OP = 6'b000011;
    localparam logic [5:0] JR_FN = 6'b001000;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       src_a;
        logic [1:0] src_b;
        logic [3:0] alu;
        logic [1:0] pcs;
        logic       illegal;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic        alu_src_a, illegal;
    logic [3:0]  alu_ctrl;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_count, instr_retired;
`endif

    obs_t got;
    assign got = {pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
                  pc_source, illegal};

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] ncyc = 0;
    logic [31:0] nret = 0;
    logic        pend_ill = 1'b0;
    logic [5:0]  legal_fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    multicycle_control #(.RA_REG(5'd31)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .pc_source  (pc_source),
        .illegal    (illegal)
`ifdef MC_CTRL_PERF_EN
       ,.cycle_count   (cycle_count),
        .instr_retired (instr_retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // ALU operation expected for an R-type funct; ok=0 when unsupported.
    task automatic r_model(input logic [5:0] fn, output logic [3:0] a, output logic ok);
        ok = 1'b1;
        a  = 4'b0000;
        case (fn)
            6'b100000: a = 4'b0010;
            6'b100010: a = 4'b0110;
            6'b100100: a = 4'b0000;
            6'b100101: a = 4'b0001;
            6'b101010: a = 4'b0111;
            default:   ok = 1'b0;
        endcase
    endtask

    // One clock: drive inputs at the falling edge, compare, then advance.
    task automatic cyc(input string tag, input obs_t e, input logic mr, input logic z, input obs_t mask);
        mem_ready = mr;
        zero      = z;
        #1;
        check_val(tag, 32'(got & mask), 32'(e & mask));
`ifdef MC_CTRL_PERF_EN
        check_val({tag, "_cycles"}, cycle_count, ncyc);
        check_val({tag, "_retired"}, instr_retired, nret);
`endif
        @(posedge clk);
        ncyc++;
        @(negedge clk);
    endtask

    function automatic obs_t fetch_word(input logic ready, input logic ill);
        obs_t e;
        e          = '0;
        e.mem_read = 1'b1;
        e.src_b    = 2'b01;
        e.alu      = 4'b0010;
        e.ir_write = ready;
        e.pc_en    = ready;
        e.illegal  = ill;
        return e;
    endfunction

    function automatic obs_t decode_word();
        obs_t e;
        e       = '0;
        e.src_b = 2'b11;
        e.alu   = 4'b0010;
        return e;
    endfunction

    function automatic obs_t addr_word();
        obs_t e;
        e       = '0;
        e.src_a = 1'b1;
        e.src_b = 2'b10;
        e.alu   = 4'b0010;
        return e;
    endfunction

    // Full instruction: fw/mw are wait cycles in fetch and in the data access.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic z);
        obs_t e, full, nalu;
        logic [3:0] a;
        logic ok;
        logic retire;
        full     = '1;
        nalu     = '1;
        nalu.alu = 4'b0000;
        opcode   = op;
        funct    = fn;
        for (int k = 0; k <= fw; k++) begin
            cyc("fetch", fetch_word(k == fw, (k == 0) && pend_ill), k == fw, rbit(), full);
        end
        pend_ill = 1'b0;
        cyc("decode", decode_word(), rbit(), rbit(), full);
        retire = 1'b1;
        if (op == LW_OP || op == SW_OP) begin
            cyc("mem_addr", addr_word(), rbit(), rbit(), full);
            for (int k = 0; k <= mw; k++) begin
                e        = '0;
                e.i_or_d = 1'b1;
                if (op == LW_OP) e.mem_read = 1'b1;
                else             e.mem_write = 1'b1;
                cyc((op == LW_OP) ? "mem_rd" : "mem_wr", e, k == mw, rbit(), full);
            end
            if (op == LW_OP) begin
                e            = '0;
                e.reg_write  = 1'b1;
                e.mem_to_reg = 2'b01;
                cyc("mem_wb", e, rbit(), rbit(), full);
            end
        end else if (op == R_OP && fn == JR_FN) begin
            e       = '0;
            e.pc_en = 1'b1;
            e.pcs   = 2'b11;
            cyc("jr", e, rbit(), rbit(), full);
        end else if (op == R_OP) begin
            r_model(fn, a, ok);
            e       = '0;
            e.src_a = 1'b1;
            e.alu   = a;
            cyc("exec_r", e, rbit(), rbit(), ok ? full : nalu);
            if (ok) begin
                e           = '0;
                e.reg_write = 1'b1;
                e.reg_dst   = 2'b01;
                cyc("alu_wb", e, rbit(), rbit(), full);
            end else begin
                pend_ill = 1'b1;
                retire   = 1'b0;
            end
        end else if (op == ADDI_OP) begin
            cyc("exec_i", addr_word(), rbit(), rbit(), full);
            e           = '0;
            e.reg_write = 1'b1;
            cyc("i_wb", e, rbit(), rbit(), full);
        end else if (op == BEQ_OP) begin
            e       = '0;
            e.src_a = 1'b1;
            e.alu   = 4'b0110;
            e.pcs   = 2'b01;
            e.pc_en = z;
            cyc("branch", e, rbit(), z, full);
        end else if (op == J_OP || op == JAL_OP) begin
            e       = '0;
            e.pc_en = 1'b1;
            e.pcs   = 2'b10;
            if (op == JAL_OP) begin
                e.reg_write  = 1'b1;
                e.reg_dst    = 2'b10;
                e.mem_to_reg = 2'b10;
            end
            cyc((op == JAL_OP) ? "jal" : "jump", e, rbit(), rbit(), full);
        end else begin
            pend_ill = 1'b1;
            retire   = 1'b0;
        end
        if (retire) nret++;
    endtask

    task automatic run_random(input int count);
        logic [5:0] op, fn;
        for (int i = 0; i < count; i++) begin
            fn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 9))
                0: begin op = R_OP; fn = legal_fns[$urandom_range(0, 4)]; end
                1: begin op = R_OP; fn = JR_FN; end
                2: op = R_OP;
                3: op = LW_OP;
                4: op = SW_OP;
                5: op = BEQ_OP;
                6: op = ADDI_OP;
                7: op = J_OP;
                8: op = JAL_OP;
                default: op = 6'($urandom_range(0, 63));
            endcase
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
        end
    endtask

    initial begin
        obs_t e, full;
        full      = '1;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        opcode    = R_OP;
        funct     = 6'b100000;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_outputs", 32'(got), 32'(fetch_word(1'b0, 1'b0)));
`ifdef MC_CTRL_PERF_EN
        check_val("reset_cycles", cycle_count, 32'd0);
        check_val("reset_retired", instr_retired, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(R_OP, 6'b100000, 0, 0, 1'b0);
        run_instr(LW_OP, 6'b000000, 0, 2, 1'b0);
        run_instr(BEQ_OP, 6'b000000, 0, 0, 1'b1);
        run_instr(BEQ_OP, 6'b000000, 0, 0, 1'b0);
        run_instr(JAL_OP, 6'b000000, 0, 0, 1'b0);
        run_instr(6'b000111, 6'b000000, 0, 0, 1'b0);
        run_instr(R_OP, 6'b000000, 1, 0, 1'b0);
        run_instr(SW_OP, 6'b000000, 2, 1, 1'b0);

        run_random(300);

        // Store abandoned by reset while waiting on memory.
        opcode = SW_OP;
        funct  = 6'b000000;
        cyc("abort_fetch", fetch_word(1'b1, pend_ill), 1'b1, 1'b0, full);
        pend_ill = 1'b0;
        cyc("abort_decode", decode_word(), 1'b0, 1'b0, full);
        cyc("abort_addr", addr_word(), 1'b0, 1'b0, full);
        mem_ready = 1'b0;
        #1;
        check_val("abort_mem_wr_pre", 32'(mem_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_outputs", 32'(got), 32'(fetch_word(1'b0, 1'b0)));
`ifdef MC_CTRL_PERF_EN
        check_val("abort_cycles", cycle_count, 32'd0);
        check_val("abort_retired", instr_retired, 32'd0);
`endif
        ncyc = 0;
        nret = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(ADDI_OP, 6'b000000, 0, 0, 1'b0);
        run_random(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
